// File: rtl/vram_user_arbiter.sv
// vram_user_arbiter: round-robin arbiter of two byte requesters onto one VRAM user port.
// Define VRAM_CLEAR_EN to include the whole-VRAM fill engine (clear_start/clear_value/clear_busy).
module vram_user_arbiter #(
    parameter int VRAM_DEPTH = 24576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [14:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    output logic        a_rvalid,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [14:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic        b_rvalid,
    input  logic        clear_start,
    input  logic [7:0]  clear_value,
    output logic        clear_busy,
    output logic [14:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    input  logic [7:0]  vram_rdata
);
`ifdef VRAM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_t;
    localparam logic [14:0] LAST_ADDR = 15'(VRAM_DEPTH - 1);
    logic       pend_q, pend_d;
    logic [7:0] val_q, val_d;
`else
    typedef enum logic {IDLE, ACCESS} state_t;
`endif
    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  rd_q, rd_d;
    logic        a_rvalid_q, b_rvalid_q;
    logic [7:0]  a_rdata_q, b_rdata_q;
    logic        grant_b;
    // last_b_q=1 means b was granted last, so a wins a tie
    assign grant_b = b_req && (!a_req || !last_b_q);
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        rd_d     = 2'b00;
`ifdef VRAM_CLEAR_EN
        pend_d   = pend_q;
        val_d    = val_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef VRAM_CLEAR_EN
                if (clear_start || pend_q) begin
                    state_d = CLEAR;
                    pend_d  = 1'b0;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    wdata_d = clear_start ? clear_value : val_q;
                end else
`endif
                if (a_req || b_req) begin
                    state_d  = ACCESS;
                    last_b_d = grant_b;
                    a_ack_d  = !grant_b;
                    b_ack_d  = grant_b;
                    addr_d   = grant_b ? b_addr : a_addr;
                    we_d     = grant_b ? b_we : a_we;
                    wdata_d  = grant_b ? b_wdata : a_wdata;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                rd_d    = {b_ack_q & ~we_q, a_ack_q & ~we_q};
`ifdef VRAM_CLEAR_EN
                if (clear_start) begin
                    pend_d = 1'b1;
                    val_d  = clear_value;
                end
`endif
            end
`ifdef VRAM_CLEAR_EN
            CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + 15'd1;
                    we_d   = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rd_q       <= 2'b00;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            a_rvalid_q <= rd_q[0];
            b_rvalid_q <= rd_q[1];
            if (rd_q[0]) a_rdata_q <= vram_rdata;
            if (rd_q[1]) b_rdata_q <= vram_rdata;
        end
    end
`ifdef VRAM_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            val_q  <= '0;
        end else begin
            pend_q <= pend_d;
            val_q  <= val_d;
        end
    end
    assign clear_busy = (state_q == CLEAR);
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_value, 32'(VRAM_DEPTH)};
    assign clear_busy   = 1'b0;
`endif
    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign vram_we    = we_q;
endmodule

// File: tb/tb_vram_user_arbiter.sv
// tb_vram_user_arbiter: directed bench with a VRAM memory model and a behavioural
// reference of the arbiter checked every cycle, plus hand-computed expectations.
module tb_vram_user_arbiter;
    localparam int DEPTH = 24576;
`ifdef VRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, clear_start = 1'b0;
    logic [14:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0, clear_value = '0;
    logic        a_ack, b_ack, a_rvalid, b_rvalid, clear_busy, vram_we;
    logic [7:0]  a_rdata, b_rdata, vram_wdata;
    logic [7:0]  vram_rdata = '0;
    logic [14:0] vram_addr;
    int          checks = 0, errors = 0, cyc = 0;

    vram_user_arbiter #(.VRAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // VRAM: unwritten bytes read as (addr[7:0] ^ 0x55); read data valid one clk after the address
    logic [7:0] mem [DEPTH];
    bit         written [DEPTH];
    function automatic logic [7:0] rd_mem(input int a);
        return written[a] ? mem[a] : (8'(a) ^ 8'h55);
    endfunction
    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr]     <= vram_wdata;
            written[vram_addr] <= 1'b1;
        end
        vram_rdata <= rd_mem(int'(vram_addr));
    end

    // Reference model: mode 0 idle, 1 access, 2 clear; shadow memory supplies expected read data
    int         m_phase = 0, m_idx = 0;
    bit         m_lastb = 1'b1, m_pend = 1'b0, gb;
    logic [7:0] m_pval = '0;
    bit         s1_v = 0, s1_b = 0, s2_v = 0, s2_b = 0;
    logic [7:0] s1_d = '0, s2_d = '0;
    logic [7:0] sh [DEPTH];
    bit         sh_w [DEPTH];
    logic       e_aack = 0, e_back = 0, e_arv = 0, e_brv = 0, e_busy = 0, e_we = 0;
    logic [7:0] e_ard = '0, e_brd = '0, e_wd = '0;
    logic [14:0] e_addr = '0;
    function automatic logic [7:0] sh_rd(input int a);
        return sh_w[a] ? sh[a] : (8'(a) ^ 8'h55);
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_lastb = 1'b1; m_pend = 1'b0; s1_v = 0; s2_v = 0;
            e_aack = 0; e_back = 0; e_arv = 0; e_brv = 0; e_busy = 0; e_we = 0;
            e_ard = '0; e_brd = '0; e_wd = '0; e_addr = '0;
        end else begin
            e_aack = 0; e_back = 0; e_we = 0; e_arv = 0; e_brv = 0;
            if (s2_v) begin
                if (s2_b) begin e_brv = 1; e_brd = s2_d; end
                else begin e_arv = 1; e_ard = s2_d; end
            end
            s2_v = s1_v; s2_b = s1_b; s2_d = s1_d; s1_v = 0;
            if (m_phase == 1) begin
                m_phase = 0;
                if (CLR_EN && clear_start) begin m_pend = 1; m_pval = clear_value; end
            end else if (m_phase == 2) begin
                if (m_idx == DEPTH - 1) begin
                    m_phase = 0; e_busy = 0;
                end else begin
                    m_idx++; e_we = 1; e_addr = 15'(m_idx);
                    sh[m_idx] = e_wd; sh_w[m_idx] = 1;
                end
            end else if (CLR_EN && (clear_start || m_pend)) begin
                m_phase = 2; m_idx = 0; m_pend = 0; e_busy = 1; e_we = 1; e_addr = '0;
                e_wd = clear_start ? clear_value : m_pval;
                sh[0] = e_wd; sh_w[0] = 1;
            end else if (a_req || b_req) begin
                gb = (a_req && b_req) ? !m_lastb : b_req;
                m_phase = 1; m_lastb = gb; e_aack = !gb; e_back = gb;
                e_addr = gb ? b_addr : a_addr;
                e_we   = gb ? b_we : a_we;
                e_wd   = gb ? b_wdata : a_wdata;
                if (e_we) begin sh[e_addr] = e_wd; sh_w[e_addr] = 1; end
                else begin s1_v = 1; s1_b = gb; s1_d = sh_rd(int'(e_addr)); end
            end
        end
    end

    task automatic step();
        logic [44:0] got, want;
        @(negedge clk);
        got  = {a_ack, b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata, clear_busy, vram_we, vram_addr, vram_wdata};
        want = {e_aack, e_back, e_arv, e_brv, e_ard, e_brd, e_busy, e_we, e_addr, e_wd};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle_model cyc=%0d got=%h expected=%h", cyc, got, want);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input bit is_b, input bit we, input logic [14:0] addr, input logic [7:0] d,
                          output int ack_cyc);
        if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = d; end
        else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = d; end
        ack_cyc = -1;
        for (int i = 0; i < 30000 && ack_cyc < 0; i++) begin
            step();
            if (is_b ? b_ack : a_ack) ack_cyc = cyc;
        end
        chk("ack_seen", ack_cyc >= 0, 1);
        if (is_b) b_req = 0; else a_req = 0;
    endtask

    task automatic wait_rv(input bit is_b, output int rv_cyc);
        rv_cyc = -1;
        for (int i = 0; i < 10 && rv_cyc < 0; i++) begin
            step();
            if (is_b ? b_rvalid : a_rvalid) rv_cyc = cyc;
        end
        chk("rvalid_seen", rv_cyc >= 0, 1);
    endtask

    int         t1, t2, t3, n, both, cnt, fall, back, bearly, bad;
    logic [3:0] seq;
    bit         hit;

    initial begin
        #2 rst_n = 1'b0;
        step();
        chk("reset_outputs", 64'({a_ack, b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata,
                                  clear_busy, vram_we, vram_addr, vram_wdata}), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        a_req = 1; a_we = 0; a_addr = 15'h5;
        b_req = 1; b_we = 0; b_addr = 15'h6;
        seq = '0; n = 0; both = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            step();
            if (a_ack && b_ack) both++;
            if (a_ack || b_ack) begin seq = {seq[2:0], b_ack}; n++; end
        end
        a_req = 0; b_req = 0;
        chk("rr_order_abab", seq, 4'b0101);
        chk("rr_no_double_ack", both, 0);
        repeat (4) step();
        do_req(0, 1, 15'h10, 8'hA5, t1);
        do_req(0, 0, 15'h10, 8'h00, t2);
        chk("ack_spacing_ge2", t2 - t1 >= 2, 1);
        wait_rv(0, t3);
        chk("a_read_latency", t3 - t2, 2);
        chk("a_rdata_A5", a_rdata, 8'hA5);
        do_req(1, 1, 15'h20, 8'h77, t1);
        do_req(1, 0, 15'h20, 8'h00, t2);
        wait_rv(1, t3);
        chk("b_read_latency", t3 - t2, 2);
        chk("b_rdata_77", b_rdata, 8'h77);
        chk("a_rdata_held", a_rdata, 8'hA5);
        do_req(0, 0, 15'h0123, 8'h00, t1);
        wait_rv(0, t3);
        chk("a_rdata_init_pattern", a_rdata, 8'h76);
        do_req(0, 0, 15'h10, 8'h00, t1);
        step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin step(); if (a_rvalid) cnt++; end
        chk("reset_drops_rvalid", cnt, 0);
        chk("reset_clears_rdata", a_rdata, 8'h00);
`ifdef VRAM_CLEAR_EN
        clear_value = 8'h3C; clear_start = 1;
        n = 0; fall = -1; bearly = 0; back = -1;
        for (int i = 0; i < 30000 && fall < 0; i++) begin
            step();
            if (clear_busy) begin
                n++;
                if (b_ack) bearly++;
                if (n == 1) clear_start = 0;
                if (n == 50) begin clear_start = 1; clear_value = 8'h99; end
                if (n == 51) clear_start = 0;
                if (n == 100) begin b_req = 1; b_we = 0; b_addr = 15'h3; end
            end else if (n > 0) fall = cyc;
        end
        for (int i = 0; i < 5 && back < 0; i++) begin
            step();
            if (b_ack) back = cyc;
        end
        b_req = 0;
        chk("clear_busy_cycles", n, DEPTH);
        chk("no_b_ack_during_clear", bearly, 0);
        chk("b_ack_after_clear_idle", back - fall, 1);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (rd_mem(a) !== 8'h3C) bad++;
        chk("fill_all_3C", bad, 0);
        do_req(0, 0, 15'h5FFF, 8'h00, t1);
        wait_rv(0, t3);
        chk("read_5FFF_after_fill", a_rdata, 8'h3C);
        chk("b_read_during_clear_data", b_rdata, 8'h3C);
        a_req = 1; a_we = 0; a_addr = 15'h7;
        t1 = -1;
        for (int i = 0; i < 10 && t1 < 0; i++) begin step(); if (a_ack) t1 = cyc; end
        chk("pend_ack_seen", t1 >= 0, 1);
        a_req = 0; clear_start = 1; clear_value = 8'h5A;
        step();
        clear_start = 0;
        step();
        chk("pending_clear_entry", {clear_busy, vram_we, vram_addr, vram_wdata}, {1'b1, 1'b1, 15'h0, 8'h5A});
        hit = 0;
        for (int i = 0; i < 6000 && !hit; i++) begin
            step();
            if (vram_we && vram_addr == 15'h1000) hit = 1;
        end
        chk("fill_reaches_1000", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_kills_fill_now", {vram_we, clear_busy}, 2'b00);
        step(); step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (50) begin step(); if (vram_we || clear_busy) cnt++; end
        chk("no_writes_after_abort", cnt, 0);
        chk("mem_0FFF_refilled", rd_mem(15'h0FFF), 8'h5A);
        chk("mem_1000_kept", rd_mem(15'h1000), 8'h3C);
        chk("mem_1001_kept", rd_mem(15'h1001), 8'h3C);
`else
        clear_value = 8'h3C; clear_start = 1;
        step();
        clear_start = 0;
        n = 0; cnt = 0;
        repeat (10) begin step(); if (clear_busy) n++; if (vram_we) cnt++; end
        chk("clear_busy_stays_0", n, 0);
        chk("no_fill_writes", cnt, 0);
        do_req(1, 1, 15'h30, 8'hC3, t1);
        do_req(1, 0, 15'h30, 8'h00, t2);
        wait_rv(1, t3);
        chk("noclr_ack_spacing", t2 - t1, 2);
        chk("noclr_read_latency", t3 - t2, 2);
        chk("noclr_b_rdata_C3", b_rdata, 8'hC3);
`endif
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
